midi_note_ctrl: RTL and testbench
=================================

// Module: midi_note_ctrl
// PURPOSE
//   Upstream control stage for the oscillator. Consumes a MIDI byte stream from the UART receiver.
//   Parses Note On/Off and CC messages for one channel, with running status.
//   Keeps a last-note-priority note stack.
//   Drives the oscillator's note, enable and phase-reset inputs.
// PARAMETERS
//   CHANNEL      4'd0   MIDI channel accepted (0..15); voice messages on other channels are ignored
//   STACK_DEPTH  4      held-note stack entries (2..8)
//   RETRIGGER    1      1: phase-reset pulse on every accepted Note On; 0: only when stack was empty (legato)
// PORTS
//   clk_i        in   1  system clock
//   rst_i        in   1  synchronous reset, active-high
//   byte_i       in   8  received MIDI byte
//   byteValid_i  in   1  one-cycle strobe, byte_i valid; may assert every cycle; no backpressure
//   note_o       out  8  current note number (bit 7 always 0), to oscillator note input
//   enable_o     out  1  high while stack non-empty, to oscillator enable input
//   nrstPhase_o  out  1  active-low one-cycle phase-reset pulse, to oscillator phase-reset input
//   velocity_o   out  7  velocity of most recent accepted Note On
// BEHAVIOUR
//   Reset values: note_o=0, enable_o=0, nrstPhase_o=1, velocity_o=0, stack empty, parser IDLE, no running status.
//   Reset priority: rst_i wins over byteValid_i in the same cycle; a partial message is discarded.
//   Parser FSM states: IDLE, WAIT_D1, WAIT_D2. Bytes are evaluated only when byteValid_i=1.
//   - 0xF8..0xFF (real-time): ignored completely; no state or running-status change, even mid-message.
//   - 0xF0..0xF7 (system common/SysEx): clear running status -> IDLE.
//   - Status 0x8n/0x9n/0xBn, n==CHANNEL: latch as running status -> WAIT_D1.
//   - Status 0x8x..0xEx, other channel or other type: latch as "ignore" status -> WAIT_D1.
//     Data bytes are still counted: 1 for 0xCx/0xDx, else 2.
//   - Data byte in IDLE: dropped.
//   - Data byte in WAIT_D1: latch d1; 2-byte message -> WAIT_D2; 1-byte message completes -> WAIT_D1.
//   - Data byte in WAIT_D2: message completes -> WAIT_D1 (running status retained).
//   Message actions, applied on the completing byte's cycle; outputs registered, visible the next cycle:
//   - Note On, vel>0: remove d1 from stack if present, then push it on top.
//     If the stack is full, drop the oldest (bottom) entry. velocity_o <= vel.
//   - Note On vel=0, or Note Off (any velocity): remove d1 if present and compact; absent note is a no-op.
//   - CC 123 (All Notes Off, any value): clear the stack. Other CC numbers: no-op.
//   Outputs:
//   - note_o = top of stack; holds its last value when the stack empties.
//   - enable_o = stack non-empty.
//   - On Note Off of the top note with entries remaining, note_o falls back to the next entry.
//     No phase-reset pulse is generated for this fallback.
//   - nrstPhase_o = 0 for exactly one cycle, aligned with the note_o update, on an accepted Note On.
//     With RETRIGGER=0, the pulse occurs only if the stack was empty before the Note On.
//   - Back-to-back completing messages on consecutive cycles: each is applied; a pulse per qualifying Note On.
// STRUCTURE
//   Shared package synth_pkg:
//   - MIDI status constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, CC=4'hB, PROG=4'hC, CHPRESS=4'hD.
//   - CC_ALL_NOTES_OFF=7'd123.
//   - NOTE_W=8.
//   - Parser state encoding.
//   Submodule note_stack (STACK_DEPTH): push/remove/clear ops, single-cycle.
//   note_stack exposes top, empty and full; push and remove share one combinational compaction path.
//   midi_note_ctrl holds the parser FSM and the output registers.
// TESTING
//   1. 0x90,0x3C,0x64 -> next cycle note_o=0x3C, enable_o=1, velocity_o=0x64, nrstPhase_o low 1 cycle.
//   2. Running status: 0x90,0x3C,0x64,0x40,0x50 -> note_o=0x40.
//      Then 0x40,0x00 -> note_o=0x3C, enable_o=1, no pulse.
//   3. Overflow, depth 4: Note On 60,62,64,65,67 -> top 67.
//      Then Note Off 67,65,64,62 -> enable_o=0, note 60 dropped, note_o holds 62.
//   4. Interleaving: 0x90,0x3C,0xF8,0x64 -> same as test 1. 0x91,0x3C,0x64 -> no change.
//      0xC0,0x05,0x3C -> 0x3C dropped, no change.
//   5. 0xB0,0x7B,0x00 with 3 notes held -> enable_o=0 next cycle.
//      RETRIGGER=0: legato Note On while held -> no pulse.
//   6. rst_i asserted between 0x90 and 0x3C, then 0x3C,0x64 -> no change; all outputs at reset values.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared MIDI constants and parser state encoding for the synth control path.
package synth_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  localparam int unsigned NOTE_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_D1 = 2'd1;
  localparam logic [1:0] ST_WAIT_D2 = 2'd2;

  // Program Change and Channel Pressure carry a single data byte.
  function automatic logic is_one_byte(input logic [3:0] kind);
    return (kind == PROG) || (kind == CHPRESS);
  endfunction

endpackage

// File: rtl/midi_note_ctrl_note_stack.sv
// Last-note-priority held-note stack; index 0 is the oldest entry, r_count-1 the top.
module note_stack
  import synth_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       remove_i,
  input  logic       clear_i,
  input  logic [6:0] note_i,
  output logic [6:0] top_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

  logic [6:0]             r_stack [STACK_DEPTH];
  logic [CW-1:0]          r_count;
  logic [STACK_DEPTH-1:0] w_hit;
  logic                   w_found;
  logic [6:0]             w_comp  [STACK_DEPTH];
  logic [CW-1:0]          w_comp_count;
  logic [6:0]             w_next  [STACK_DEPTH];
  logic [CW-1:0]          w_next_count;

  // Removing note_i (if held) is shared by both push and remove.
  always_comb begin
    w_found = 1'b0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      w_hit[i] = (CW'(i) < r_count) && (r_stack[i] == note_i);
    end
    for (int i = 0; i < STACK_DEPTH - 1; i++) begin
      w_found   = w_found | w_hit[i];
      w_comp[i] = w_found ? r_stack[i+1] : r_stack[i];
    end
    w_comp[STACK_DEPTH-1] = r_stack[STACK_DEPTH-1];
    w_comp_count = (|w_hit) ? (r_count - CW'(1)) : r_count;
  end

  always_comb begin
    w_next       = r_stack;
    w_next_count = r_count;
    if (clear_i) begin
      w_next_count = '0;
    end else if (push_i) begin
      if (w_comp_count == CW'(STACK_DEPTH)) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) begin
          w_next[i] = w_comp[i+1];
        end
        w_next[STACK_DEPTH-1] = note_i;
        w_next_count          = CW'(STACK_DEPTH);
      end else begin
        w_next = w_comp;
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (CW'(i) == w_comp_count) w_next[i] = note_i;
        end
        w_next_count = w_comp_count + CW'(1);
      end
    end else if (remove_i) begin
      w_next       = w_comp;
      w_next_count = w_comp_count;
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (CW'(i + 1) == r_count) top_o = r_stack[i];
    end
  end

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(STACK_DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stack <= '{default: '0};
      r_count <= '0;
    end else begin
      r_stack <= w_next;
      r_count <= w_next_count;
    end
  end

endmodule

// File: rtl/midi_note_ctrl.sv
// MIDI byte-stream parser (one channel, running status) driving the oscillator from a note stack.
module midi_note_ctrl
  import synth_pkg::*;
#(
  parameter logic [3:0]  CHANNEL     = 4'd0,
  parameter int unsigned STACK_DEPTH = 4,
  parameter bit          RETRIGGER   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_i,
  input  logic              byteValid_i,
  output logic [NOTE_W-1:0] note_o,
  output logic              enable_o,
  output logic              nrstPhase_o,
  output logic [6:0]        velocity_o
);

  logic [1:0] r_state, w_state_d;
  logic [3:0] r_kind, w_kind_d;
  logic       r_ours, w_ours_d;
  logic [6:0] r_d1, w_d1_d;
  logic [6:0] r_hold;
  logic [6:0] r_vel;
  logic       r_nrst;

  logic       w_done;
  logic [6:0] w_c1;
  logic [6:0] w_c2;
  logic       w_push, w_remove, w_clear;
  logic [6:0] w_top;
  logic       w_empty;

  always_comb begin
    w_state_d = r_state;
    w_kind_d  = r_kind;
    w_ours_d  = r_ours;
    w_d1_d    = r_d1;
    w_done    = 1'b0;
    w_c1      = r_d1;
    w_c2      = byte_i[6:0];
    if (byteValid_i) begin
      if (byte_i[7:3] == 5'b11111) begin
        // Real-time bytes pass through without touching parser state.
      end else if (byte_i[7:4] == 4'hF) begin
        w_state_d = ST_IDLE;
      end else if (byte_i[7]) begin
        w_kind_d  = byte_i[7:4];
        w_ours_d  = (byte_i[3:0] == CHANNEL) &&
                    ((byte_i[7:4] == NOTE_OFF) || (byte_i[7:4] == NOTE_ON) || (byte_i[7:4] == CC));
        w_state_d = ST_WAIT_D1;
      end else begin
        case (r_state)
          ST_WAIT_D1: begin
            w_d1_d = byte_i[6:0];
            if (is_one_byte(r_kind)) begin
              w_done = 1'b1;
              w_c1   = byte_i[6:0];
            end else begin
              w_state_d = ST_WAIT_D2;
            end
          end
          ST_WAIT_D2: begin
            w_done    = 1'b1;
            w_state_d = ST_WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_push   = w_done && r_ours && (r_kind == NOTE_ON) && (w_c2 != 7'd0);
  assign w_remove = w_done && r_ours &&
                    ((r_kind == NOTE_OFF) || ((r_kind == NOTE_ON) && (w_c2 == 7'd0)));
  assign w_clear  = w_done && r_ours && (r_kind == CC) && (w_c1 == CC_ALL_NOTES_OFF);

  note_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .remove_i(w_remove),
    .clear_i (w_clear),
    .note_i  (w_c1),
    .top_o   (w_top),
    .empty_o (w_empty),
    .full_o  ()
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_kind  <= 4'h0;
      r_ours  <= 1'b0;
      r_d1    <= 7'd0;
      r_hold  <= 7'd0;
      r_vel   <= 7'd0;
      r_nrst  <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_kind  <= w_kind_d;
      r_ours  <= w_ours_d;
      r_d1    <= w_d1_d;
      if (!w_empty) r_hold <= w_top;
      if (w_push) r_vel <= w_c2;
      r_nrst <= !(w_push && (RETRIGGER || w_empty));
    end
  end

  // Once the stack empties the last top note keeps driving the oscillator.
  assign note_o      = {1'b0, (w_empty ? r_hold : w_top)};
  assign enable_o    = !w_empty;
  assign nrstPhase_o = r_nrst;
  assign velocity_o  = r_vel;

endmodule

// File: tb/tb_midi_note_ctrl.sv
// Bench for midi_note_ctrl: queue-based reference model checked every cycle, plus literal checks.
module tb_midi_note_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bval;
  logic       bvalid;

  logic [7:0] note_a, note_b;
  logic       en_a, en_b, nrst_a, nrst_b;
  logic [6:0] vel_a, vel_b;

  always #5 clk = ~clk;

  midi_note_ctrl #(.CHANNEL(4'd0), .STACK_DEPTH(4), .RETRIGGER(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .byte_i(bval), .byteValid_i(bvalid),
    .note_o(note_a), .enable_o(en_a), .nrstPhase_o(nrst_a), .velocity_o(vel_a)
  );

  midi_note_ctrl #(.CHANNEL(4'd0), .STACK_DEPTH(4), .RETRIGGER(1'b0)) dut_leg (
    .clk_i(clk), .rst_i(rst), .byte_i(bval), .byteValid_i(bvalid),
    .note_o(note_b), .enable_o(en_b), .nrstPhase_o(nrst_b), .velocity_o(vel_b)
  );

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: status byte (-1 = none), pending data bytes, held notes (back = newest).
  int m_status = -1;
  int m_data[$];
  int m_stk[$];
  int m_note = 0;
  int m_vel  = 0;
  int m_p1   = 1;
  int m_p0   = 1;

  task automatic m_remove(input int n);
    for (int i = 0; i < m_stk.size(); i++) begin
      if (m_stk[i] == n) begin
        m_stk.delete(i);
        break;
      end
    end
  endtask

  task automatic m_apply(input int need);
    int kind, d1, d2;
    bit was_empty;
    if ((m_status & 15) != 0) return;
    kind = m_status >> 4;
    d1   = m_data[0];
    d2   = (need == 2) ? m_data[1] : 0;
    if (kind == 9 && d2 > 0) begin
      was_empty = (m_stk.size() == 0);
      m_remove(d1);
      if (m_stk.size() == 4) void'(m_stk.pop_front());
      m_stk.push_back(d1);
      m_vel = d2;
      m_p1  = 0;
      if (was_empty) m_p0 = 0;
    end else if (kind == 8 || kind == 9) begin
      m_remove(d1);
    end else if (kind == 11 && d1 == 123) begin
      m_stk.delete();
    end
  endtask

  task automatic m_byte(input int b);
    int need;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      m_status = -1;
      m_data.delete();
      return;
    end
    if (b >= 'h80) begin
      m_status = b;
      m_data.delete();
      return;
    end
    if (m_status < 0) return;
    m_data.push_back(b);
    need = ((m_status >> 4) == 12 || (m_status >> 4) == 13) ? 1 : 2;
    if (m_data.size() == need) begin
      m_apply(need);
      m_data.delete();
    end
  endtask

  always @(posedge clk) begin
    m_p1 = 1;
    m_p0 = 1;
    if (rst) begin
      m_status = -1;
      m_data.delete();
      m_stk.delete();
      m_note = 0;
      m_vel  = 0;
    end else if (bvalid) begin
      m_byte(int'(bval));
    end
    if (m_stk.size() > 0) m_note = m_stk[$];
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model_note",     note_a, m_note);
      check("model_enable",   en_a,   m_stk.size() > 0);
      check("model_nrst",     nrst_a, m_p1);
      check("model_vel",      vel_a,  m_vel);
      check("model_leg_note", note_b, m_note);
      check("model_leg_en",   en_b,   m_stk.size() > 0);
      check("model_leg_nrst", nrst_b, m_p0);
      check("model_leg_vel",  vel_b,  m_vel);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bval   = b;
    bvalid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    bvalid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bs[$]);
    foreach (bs[i]) send(bs[i]);
    idle();
  endtask

  initial begin
    rst    = 1'b1;
    bval   = 8'h00;
    bvalid = 1'b0;
    repeat (2) @(negedge clk);
    armed = 1'b1;
    check("reset_note", note_a, 0);
    check("reset_en",   en_a,   0);
    check("reset_nrst", nrst_a, 1);
    check("reset_vel",  vel_a,  0);
    rst = 1'b0;

    // Basic Note On
    send_list('{8'h90, 8'h3C, 8'h64});
    check("t1_note", note_a, 'h3C);
    check("t1_en",   en_a,   1);
    check("t1_vel",  vel_a,  'h64);
    check("t1_pulse", nrst_a, 0);
    @(negedge clk);
    check("t1_pulse_end", nrst_a, 1);
    send_list('{8'h80, 8'h3C, 8'h40});
    check("t1_off_en", en_a, 0);

    // Running status and fallback without pulse
    send_list('{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50});
    check("t2_note", note_a, 'h40);
    send_list('{8'h40, 8'h00});
    check("t2_fallback_note", note_a, 'h3C);
    check("t2_fallback_en",   en_a,   1);
    check("t2_fallback_nrst", nrst_a, 1);
    check("t2_vel_kept",      vel_a,  'h50);
    send_list('{8'hB0, 8'h7B, 8'h00});

    // Overflow at depth 4, oldest note lost
    send_list('{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64, 8'h40, 8'h64, 8'h41, 8'h64, 8'h43, 8'h64});
    check("t3_top", note_a, 'h43);
    send_list('{8'h80, 8'h43, 8'h00, 8'h41, 8'h00, 8'h40, 8'h00, 8'h3E, 8'h00});
    check("t3_en",   en_a,   0);
    check("t3_hold", note_a, 'h3E);

    // Real-time interleave, other channel, program change data
    send_list('{8'h90, 8'h3C, 8'hF8, 8'h64});
    check("t4_note", note_a, 'h3C);
    check("t4_vel",  vel_a,  'h64);
    send_list('{8'hB0, 8'h7B, 8'h00});
    send_list('{8'h91, 8'h3C, 8'h64});
    check("t4_other_ch_en", en_a, 0);
    send_list('{8'hC0, 8'h05, 8'h3C});
    check("t4_prog_en", en_a, 0);
    send_list('{8'hF0, 8'h3C, 8'h64});
    check("t4_sysex_en", en_a, 0);

    // All Notes Off, then legato behaviour
    send_list('{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64, 8'h40, 8'h64});
    check("t5_held_en", en_a, 1);
    send_list('{8'hB0, 8'h7B, 8'h00});
    check("t5_ano_en", en_a, 0);
    send_list('{8'h90, 8'h3C, 8'h64});
    check("t5_leg_first_pulse", nrst_b, 0);
    send_list('{8'h3E, 8'h64});
    check("t5_leg_no_pulse", nrst_b, 1);
    check("t5_retrig_pulse", nrst_a, 0);
    check("t5_leg_note",     note_b, 'h3E);

    // Back-to-back completions via one-byte Program Change, then reset mid-message
    send_list('{8'hC0, 8'h01, 8'h02, 8'h03});
    send(8'h90);
    @(negedge clk);
    rst  = 1'b1;
    bval = 8'h3C;
    @(negedge clk);
    rst    = 1'b0;
    bvalid = 1'b0;
    send_list('{8'h3C, 8'h64});
    check("t6_note", note_a, 0);
    check("t6_en",   en_a,   0);
    check("t6_nrst", nrst_a, 1);
    check("t6_vel",  vel_a,  0);

    repeat (2) @(negedge clk);
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
